// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops show-ahead FIFO words and streams them out as narrow beats, LSB slice first
module fifo_rd_stream #(
  parameter int DWID = 16,
  parameter int OWID = 8,
  parameter int CNT_WID = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               fifo_empty_i,
  input  logic [DWID-1:0]    fifo_rdata_i,
  output logic               fifo_rd_o,
  output logic               m_valid_o,
  output logic [OWID-1:0]    m_data_o,
  output logic               m_last_o,
  input  logic               m_ready_i,
  output logic               busy_o,
  output logic [CNT_WID-1:0] word_cnt_o
);
  localparam int RATIO = DWID / OWID;
  localparam int BWID = RATIO > 1 ? $clog2(RATIO) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [DWID-1:0] sh;
  logic [BWID-1:0] beat;
  logic fetch, last, xfer;
  assign fetch = en_i & ~fifo_empty_i;
  assign last = beat == BWID'(RATIO - 1);
  assign xfer = state == SEND & m_ready_i;
  assign fifo_rd_o = rst & fetch & (state == IDLE | (xfer & last));
  assign m_valid_o = state == SEND;
  assign busy_o = state == SEND;
  assign m_data_o = sh[OWID-1:0];
  assign m_last_o = state == SEND & last;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      sh <= '0;
      beat <= '0;
      word_cnt_o <= '0;
    end else begin
      if (fifo_rd_o) begin
        sh <= fifo_rdata_i;
        beat <= '0;
        state <= SEND;
      end else if (xfer & last) state <= IDLE;
      else if (xfer) begin
        sh <= sh >> OWID;
        beat <= beat + BWID'(1);
      end
      if (xfer & last) word_cnt_o <= word_cnt_o + CNT_WID'(1);
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed checks of fifo_rd_stream against a queue-based FIFO model
module tb_fifo_rd_stream;
  logic clk = 0, rst = 0, en_i = 0, fifo_empty_i = 1, m_ready_i = 0;
  logic [15:0] fifo_rdata_i = '0;
  logic fifo_rd_o, m_valid_o, m_last_o, busy_o;
  logic [7:0] m_data_o;
  logic [15:0] word_cnt_o;
  logic c2_rd, c2_valid, c2_last, c2_busy;
  logic [7:0] c2_data;
  logic [1:0] c2_cnt;
  int n_chk = 0, n_err = 0;
  logic [15:0] q[$];
  logic [8:0] beats[$];
  int pops[$], beat_cyc[$];
  fifo_rd_stream dut (
    .clk(clk), .rst(rst), .en_i(en_i), .fifo_empty_i(fifo_empty_i), .fifo_rdata_i(fifo_rdata_i),
    .fifo_rd_o(fifo_rd_o), .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o),
    .m_ready_i(m_ready_i), .busy_o(busy_o), .word_cnt_o(word_cnt_o)
  );
  fifo_rd_stream #(.CNT_WID(2)) dut_c2 (
    .clk(clk), .rst(rst), .en_i(en_i), .fifo_empty_i(fifo_empty_i), .fifo_rdata_i(fifo_rdata_i),
    .fifo_rd_o(c2_rd), .m_valid_o(c2_valid), .m_data_o(c2_data), .m_last_o(c2_last),
    .m_ready_i(m_ready_i), .busy_o(c2_busy), .word_cnt_o(c2_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_fifo();
    fifo_empty_i = q.size() == 0;
    fifo_rdata_i = q.size() > 0 ? q[0] : 16'h0;
  endtask
  // pop the model FIFO at the edge where the DUT strobed fifo_rd_o
  task automatic tick();
    logic rd;
    rd = fifo_rd_o;
    @(posedge clk);
    #1;
    if (rd && q.size() > 0) void'(q.pop_front());
    set_fifo();
  endtask
  task automatic run(input int ncyc, input bit toggle);
    logic stall, pl;
    logic [7:0] pd;
    stall = 0; pl = 0; pd = '0;
    beats.delete(); pops.delete(); beat_cyc.delete();
    for (int c = 0; c < ncyc; c++) begin
      m_ready_i = toggle ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
      #1;
      if (stall) begin
        chk("stall_valid", m_valid_o, 1);
        chk("stall_data", m_data_o, pd);
        chk("stall_last", m_last_o, pl);
      end
      if (fifo_rd_o) pops.push_back(c);
      if (m_valid_o && m_ready_i) begin
        beats.push_back({m_last_o, m_data_o});
        beat_cyc.push_back(c);
      end
      stall = m_valid_o && !m_ready_i;
      pd = m_data_o;
      pl = m_last_o;
      tick();
    end
  endtask
  initial begin
    logic [8:0] exp_b[8];
    int exp_seq[5];
    int k;
    logic fin;
    exp_b = '{9'h002, 9'h101, 9'h004, 9'h103, 9'h006, 9'h105, 9'h008, 9'h107};
    exp_seq = '{1, 2, 3, 0, 1};
    #2;
    chk("rst_rd", fifo_rd_o, 0);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_data", m_data_o, 0);
    chk("rst_last", m_last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cnt", word_cnt_o, 0);
    @(posedge clk);
    #2 rst = 1;
    en_i = 1;
    m_ready_i = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("empty_rd", fifo_rd_o, 0);
      chk("empty_valid", m_valid_o, 0);
      chk("empty_cnt", word_cnt_o, 0);
      tick();
    end
    q.push_back(16'hA1B2);
    set_fifo();
    #1;
    chk("one_pop", fifo_rd_o, 1);
    tick();
    chk("one_b0_valid", m_valid_o, 1);
    chk("one_b0_data", m_data_o, 8'hB2);
    chk("one_b0_last", m_last_o, 0);
    chk("one_b0_busy", busy_o, 1);
    chk("one_b0_rd", fifo_rd_o, 0);
    tick();
    chk("one_b1_valid", m_valid_o, 1);
    chk("one_b1_data", m_data_o, 8'hA1);
    chk("one_b1_last", m_last_o, 1);
    tick();
    chk("one_idle_valid", m_valid_o, 0);
    chk("one_idle_busy", busy_o, 0);
    chk("one_cnt", word_cnt_o, 1);
    q = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
    set_fifo();
    run(10, 0);
    chk("burst_nbeats", beats.size(), 8);
    chk("burst_npops", pops.size(), 4);
    for (int i = 0; i < 8; i++) begin
      chk("burst_beat", beats[i], exp_b[i]);
      chk("burst_cyc", beat_cyc[i], i + 1);
    end
    for (int i = 0; i < 4; i++) chk("burst_pop_cyc", pops[i], 2 * i);
    chk("burst_cnt", word_cnt_o, 5);
    chk("burst_idle", m_valid_o, 0);
    q = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
    set_fifo();
    run(20, 1);
    chk("stall_nbeats", beats.size(), 8);
    chk("stall_npops", pops.size(), 4);
    for (int i = 0; i < 8; i++) chk("stall_beat", beats[i], exp_b[i]);
    for (int i = 0; i < 4; i++) chk("stall_pop_cyc", pops[i], 4 * i);
    chk("stall_cnt", word_cnt_o, 9);
    q = '{16'hCAFE, 16'h1234};
    set_fifo();
    m_ready_i = 1;
    #1;
    chk("en_pop", fifo_rd_o, 1);
    tick();
    chk("en_b0_data", m_data_o, 8'hFE);
    chk("en_b0_last", m_last_o, 0);
    tick();
    en_i = 0;
    #1;
    chk("en_b1_valid", m_valid_o, 1);
    chk("en_b1_data", m_data_o, 8'hCA);
    chk("en_b1_last", m_last_o, 1);
    chk("en_b1_rd", fifo_rd_o, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("en_off_rd", fifo_rd_o, 0);
      chk("en_off_valid", m_valid_o, 0);
      tick();
    end
    chk("en_off_qsize", q.size(), 1);
    chk("en_cnt", word_cnt_o, 10);
    q.push_back(16'h5678);
    en_i = 1;
    #1;
    chk("mid_pop", fifo_rd_o, 1);
    tick();
    chk("mid_b0_data", m_data_o, 8'h34);
    chk("mid_b0_valid", m_valid_o, 1);
    #1 rst = 0;
    #1;
    chk("mid_rst_valid", m_valid_o, 0);
    chk("mid_rst_data", m_data_o, 0);
    chk("mid_rst_last", m_last_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_cnt", word_cnt_o, 0);
    chk("mid_rst_rd", fifo_rd_o, 0);
    tick();
    rst = 1;
    #1;
    chk("rel_pop", fifo_rd_o, 1);
    tick();
    chk("rel_b0_data", m_data_o, 8'h78);
    chk("rel_b0_last", m_last_o, 0);
    tick();
    chk("rel_b1_data", m_data_o, 8'h56);
    chk("rel_b1_last", m_last_o, 1);
    tick();
    chk("rel_idle", m_valid_o, 0);
    chk("rel_cnt", word_cnt_o, 1);
    chk("rel_qsize", q.size(), 0);
    rst = 0;
    #1;
    tick();
    rst = 1;
    q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    set_fifo();
    k = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      fin = m_valid_o && m_ready_i && m_last_o;
      tick();
      if (fin) begin
        k++;
        if (k <= 5) chk("wrap_cnt", c2_cnt, exp_seq[k-1]);
        chk("wide_cnt", word_cnt_o, k);
      end
    end
    chk("wrap_words", k, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side engine for the team's synchronous show-ahead FIFO.
- Pops DWID-bit words from the FIFO read port and emits them downstream as OWID-bit beats on a valid/ready stream, least-significant slice first.
- Sits between the FIFO and narrow consumers such as byte-wide serialisers and bus bridges.
- Sustains one beat per cycle with no bubble between consecutive words while data is available and the sink is ready.

Parameters:
DWID, 16, FIFO word width in bits; must be an integer multiple of OWID.
OWID, 8, output beat width in bits.
CNT_WID, 16, width of the completed-word counter.
Derived: RATIO = DWID/OWID (beats per word, >=1); BWID = max(1,$clog2(RATIO)).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-low.
en_i  in  1  enable for fetching new words; does not abort a word in flight.
fifo_empty_i  in  1  FIFO empty flag.
fifo_rdata_i  in  DWID  FIFO head word, valid whenever fifo_empty_i=0 (show-ahead).
fifo_rd_o  out  1  pop strobe; FIFO advances its read pointer at the clock edge where this is 1.
m_valid_o  out  1  output beat valid.
m_data_o  out  OWID  output beat data.
m_last_o  out  1  high with the final beat of each word.
m_ready_i  in  1  sink ready; a beat transfers on a cycle with m_valid_o=1 and m_ready_i=1.
busy_o  out  1  high while a word is held (state SEND).
word_cnt_o  out  CNT_WID  count of fully transferred words; wraps modulo 2^CNT_WID.

Behaviour:
- Reset values (rst=0, asynchronous): state IDLE, m_valid_o=0, m_data_o=0, m_last_o=0, busy_o=0, word_cnt_o=0, beat=0, shift register=0. fifo_rd_o is forced 0 while rst=0.
- State machine has two states, IDLE and SEND.
- Registers: shift register sh[DWID-1:0]; beat counter beat[BWID-1:0].
- Pop condition: fetch = en_i & ~fifo_empty_i.
  - fifo_rd_o is combinational: fetch in IDLE, or fetch & final-beat-transfer in SEND.
  - fifo_rd_o is never 1 when fifo_empty_i=1.
- IDLE:
  - If fetch: assert fifo_rd_o, load sh<=fifo_rdata_i, beat<=0, go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - m_valid_o=1, m_data_o=sh[OWID-1:0], m_last_o=(beat==RATIO-1). All are registered or derived from registers only; no combinational path from m_ready_i.
  - No transfer (m_ready_i=0): sh, beat, m_data_o and m_last_o hold stable.
  - Transfer on a non-final beat: sh<=sh>>OWID, beat<=beat+1.
  - Transfer on the final beat: word_cnt_o<=word_cnt_o+1.
    - If fetch in the same cycle: pop, reload sh<=fifo_rdata_i, beat<=0, stay in SEND. The next beat appears in the following cycle with no bubble.
    - Otherwise go to IDLE; m_valid_o=0 from the next cycle.
- Latency: word at the FIFO head with en_i=1 in IDLE at cycle N is popped at edge N. The first beat is valid in cycle N+1. The word completes at the earliest in cycle N+RATIO.
- en_i deasserted mid-word: the current word finishes all RATIO beats; no further pop follows.
- FIFO becomes empty mid-word: no effect on the held word. Stay in IDLE until fifo_empty_i=0.
- RATIO=1: every beat has m_last_o=1. A pop can occur on every transferring cycle, giving full throughput.
- Reset asserted mid-word: the held word is discarded; all outputs return to reset values immediately. The FIFO's own reset state is independent of this block.
- word_cnt_o wraps from 2^CNT_WID-1 to 0 without a flag.

Test Plan:
- Reset, then en_i=1 with an empty FIFO -> fifo_rd_o=0, m_valid_o=0, word_cnt_o=0 for 10 cycles.
- FIFO holds 16'hA1B2, en_i=1, m_ready_i=1 -> one fifo_rd_o pulse; beats 8'hB2 (last=0) then 8'hA1 (last=1) in consecutive cycles; word_cnt_o=1; back in IDLE.
- Four words 16'h0102, 16'h0304, 16'h0506, 16'h0708 preloaded, m_ready_i=1 -> 8 consecutive valid beats 02,01,04,03,06,05,08,07; fifo_rd_o pulses on cycles 0,2,4,6; word_cnt_o=4.
- Same traffic with m_ready_i toggling 1,0,0,1,... -> m_data_o and m_last_o stable while stalled; identical beat order; no extra pops.
- en_i dropped after the first beat of 16'hCAFE -> 8'hCA still delivered with last=1; no further fifo_rd_o while en_i=0, even with the FIFO non-empty.
- rst pulsed low while m_valid_o=1 mid-word -> outputs 0 asynchronously. After release with en_i=1, the next FIFO head word is fetched and emitted from beat 0.
- CNT_WID=2 with 5 words sent -> word_cnt_o sequence 1,2,3,0,1.
